// File: rtl/rr_arbiter_2.sv
// Two-master round-robin arbiter with done/request-drop release and a hold-time limit.
// Priority pointer alternates after every grant; all outputs are registered.
module rr_arbiter_2 #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic [1:0] gnt,
  output logic       owner,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             rel, lim;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    timeout_d  = 1'b0;
    rel        = 1'b0;
    lim        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          owner_d    = req[ptr_q] ? ptr_q : ~ptr_q;
          gnt_d      = owner_d ? 2'b10 : 2'b01;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        rel = done[owner_q] | ~req[owner_q];
        lim = (hold_cnt_q == HOLD_LAST);
        if (rel || lim) begin
          // a genuine release on the limit edge wins, so no timeout then
          gnt_d     = 2'b00;
          ptr_d     = ~owner_q;
          timeout_d = ~rel;
          state_d   = RELEASE;
        end else if (hold_cnt_q != CNT_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      hold_cnt_q <= '0;
      gnt_q      <= 2'b00;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_2.sv
// Directed bench for rr_arbiter_2 (HOLD_MAX=8); each check compares {gnt,owner,busy,timeout}.
module tb_rr_arbiter_2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic [1:0] gnt;
  logic       owner, busy, timeout;
  int         vectors = 0;
  int         errors = 0;

  rr_arbiter_2 #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // advance one rising edge and settle 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 2'b00; done = 2'b00; reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11;
    step(); step();
    vectors++;
    if ({gnt, owner, busy, timeout} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_hold: got %b want 00000", {gnt, owner, busy, timeout});
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 2'b11;
    step(); step();
    vectors++;
    if ({gnt, owner, busy, timeout} !== 5'b01010) begin
      errors++;
      $display("FAIL async_pre: got %b want 01010", {gnt, owner, busy, timeout});
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({gnt, owner, busy, timeout} !== 5'b00000) begin
      errors++;
      $display("FAIL async_mid: got %b want 00000", {gnt, owner, busy, timeout});
    end
    step();
    reset = 1'b0;
    step();
    vectors++;
    if ({gnt, owner, busy, timeout} !== 5'b01010) begin
      errors++;
      $display("FAIL async_restart: got %b want 01010", {gnt, owner, busy, timeout});
    end
  endtask

  task automatic test_single();
    logic [4:0] exp [6] = '{5'b01010, 5'b01010, 5'b01010, 5'b00010, 5'b00000, 5'b00000};
    do_reset();
    req = 2'b01;
    for (int i = 0; i < 6; i++) begin
      done = (i == 3) ? 2'b01 : 2'b00;
      if (i == 4) req = 2'b00;
      step();
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp[i]) begin
        errors++;
        $display("FAIL single[%0d]: got %b want %b", i, {gnt, owner, busy, timeout}, exp[i]);
      end
    end
  endtask

  task automatic test_alternation();
    logic [4:0] exp [9] = '{5'b01010, 5'b01010, 5'b00010, 5'b00000,
                            5'b10110, 5'b10110, 5'b00110, 5'b00100, 5'b01010};
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 9; i++) begin
      done = (i == 2) ? 2'b01 : (i == 6) ? 2'b10 : 2'b00;
      step();
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp[i]) begin
        errors++;
        $display("FAIL alternate[%0d]: got %b want %b", i, {gnt, owner, busy, timeout}, exp[i]);
      end
    end
    done = 2'b00;
  endtask

  task automatic test_timeout();
    logic [4:0] exp;
    do_reset();
    req = 2'b10;
    for (int i = 0; i < 11; i++) begin
      step();
      if (i == 0) req = 2'b11;
      if (i <= 7)       exp = 5'b10110;
      else if (i == 8)  exp = 5'b00111;
      else if (i == 9)  exp = 5'b00100;
      else              exp = 5'b01010;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        errors++;
        $display("FAIL timeout[%0d]: got %b want %b", i, {gnt, owner, busy, timeout}, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp;
    do_reset();
    req = 2'b01;
    for (int i = 0; i < 10; i++) begin
      done = (i == 3) ? 2'b10 : (i == 8) ? 2'b01 : 2'b00;
      step();
      if (i <= 7)      exp = 5'b01010;
      else if (i == 8) exp = 5'b00010;
      else             exp = 5'b00000;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        errors++;
        $display("FAIL done_on_limit[%0d]: got %b want %b", i, {gnt, owner, busy, timeout}, exp);
      end
    end
    done = 2'b00;
  endtask

  task automatic test_req_drop();
    logic [4:0] exp [4] = '{5'b01010, 5'b00010, 5'b00000, 5'b10110};
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) req = 2'b10;
      step();
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp[i]) begin
        errors++;
        $display("FAIL req_drop[%0d]: got %b want %b", i, {gnt, owner, busy, timeout}, exp[i]);
      end
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if ({gnt, owner, busy, timeout} !== 5'b00000) begin
        errors++;
        $display("FAIL idle[%0d]: got %b want 00000", i, {gnt, owner, busy, timeout});
      end
    end
    req = 2'b11;
    step();
    vectors++;
    if ({gnt, owner, busy, timeout} !== 5'b01010) begin
      errors++;
      $display("FAIL idle_then_grant: got %b want 01010", {gnt, owner, busy, timeout});
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_single();
    test_alternation();
    test_timeout();
    test_simultaneous();
    test_req_drop();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
